// File: rtl/dir_req_arbiter.sv
// Round-robin arbiter feeding the single directory request port from two per-CPU FIFOs.
// One transaction is outstanding at a time; a hung directory is released by a WAIT timeout.
module dir_req_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cpu0_req_en_i,
    input  logic [3:0]        cpu0_req_type_i,
    input  logic [DATA_W-1:0] cpu0_req_data_i,
    input  logic [ADDR_W-1:0] cpu0_req_addr_i,
    output logic              cpu0_full_o,
    input  logic              cpu1_req_en_i,
    input  logic [3:0]        cpu1_req_type_i,
    input  logic [DATA_W-1:0] cpu1_req_data_i,
    input  logic [ADDR_W-1:0] cpu1_req_addr_i,
    output logic              cpu1_full_o,
    output logic              dir_req_en_o,
    output logic [3:0]        dir_req_type_o,
    output logic [DATA_W-1:0] dir_req_data_o,
    output logic [ADDR_W-1:0] dir_req_addr_o,
    output logic              dir_requester_o,
    input  logic              dir_done_i,
    output logic              busy_o,
    output logic              ovf_err_o,
    output logic              timeout_err_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int E_W   = 4 + ADDR_W + DATA_W;
    localparam logic [3:0] TYPE_NONE = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    logic [1:0]     req_en_s;
    logic [E_W-1:0] req_entry_s [2];
    logic [E_W-1:0] head_s      [2];
    logic [1:0]     full_s;
    logic [1:0]     nonempty_s;
    logic [1:0]     push_s;
    logic [1:0]     pop_s;
    logic           ovf_s;

    assign req_en_s       = {cpu1_req_en_i, cpu0_req_en_i};
    assign req_entry_s[0] = {cpu0_req_type_i, cpu0_req_addr_i, cpu0_req_data_i};
    assign req_entry_s[1] = {cpu1_req_type_i, cpu1_req_addr_i, cpu1_req_data_i};
    assign push_s         = req_en_s & ~full_s;
    assign ovf_s          = |(req_en_s & full_s);

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [E_W-1:0]   mem_r [DEPTH];
        logic [PTR_W-1:0] wr_ptr_r;
        logic [PTR_W-1:0] rd_ptr_r;
        logic [CNT_W-1:0] count_r;
        logic [CNT_W-1:0] count_nxt_s;
        logic             full_r;

        // Occupancy after this cycle's push/pop; simultaneous push and pop cancel out.
        always_comb begin
            count_nxt_s = count_r;
            case ({push_s[g], pop_s[g]})
                2'b10:   count_nxt_s = count_r + CNT_W'(1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1);
                default: count_nxt_s = count_r;
            endcase
        end

        // Storage array, written only on an accepted push.
        always_ff @(posedge sys_clk) begin
            if (push_s[g]) begin
                mem_r[wr_ptr_r] <= req_entry_s[g];
            end
        end

        // Pointers, count and registered full flag; pointers wrap modulo DEPTH.
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                count_r  <= '0;
                full_r   <= 1'b0;
            end else begin
                if (push_s[g]) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_s[g]) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
                count_r <= count_nxt_s;
                full_r  <= (count_nxt_s == CNT_W'(DEPTH));
            end
        end

        assign head_s[g]     = mem_r[rd_ptr_r];
        assign full_s[g]     = full_r;
        assign nonempty_s[g] = (count_r != CNT_W'(0));
    end

    state_t         state_r;
    state_t         state_nxt_s;
    logic           rr_r;
    logic [TMO_W-1:0] tmo_r;
    logic [TMO_W-1:0] tmo_nxt_s;
    logic [TMO_W-1:0] tmo_inc_s;
    logic           grant_s;
    logic           winner_s;
    logic           tmo_hit_s;
    logic [E_W-1:0] win_entry_s;

    assign tmo_inc_s   = tmo_r + TMO_W'(1);
    assign win_entry_s = winner_s ? head_s[1] : head_s[0];
    assign pop_s       = grant_s ? (winner_s ? 2'b10 : 2'b01) : 2'b00;

    // Next state, grant selection and timeout counting.
    always_comb begin
        state_nxt_s = state_r;
        tmo_nxt_s   = tmo_r;
        grant_s     = 1'b0;
        winner_s    = 1'b0;
        tmo_hit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (nonempty_s == 2'b11) begin
                    grant_s  = 1'b1;
                    winner_s = rr_r;
                end else if (nonempty_s[0]) begin
                    grant_s  = 1'b1;
                    winner_s = 1'b0;
                end else if (nonempty_s[1]) begin
                    grant_s  = 1'b1;
                    winner_s = 1'b1;
                end else begin
                    grant_s  = 1'b0;
                end
                state_nxt_s = grant_s ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE: begin
                tmo_nxt_s   = '0;
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion takes precedence over a timeout landing on the same cycle.
                if (dir_done_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (tmo_inc_s == TMO_W'(TIMEOUT)) begin
                    tmo_nxt_s   = tmo_inc_s;
                    tmo_hit_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    tmo_nxt_s   = tmo_inc_s;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    logic              dir_req_en_r;
    logic [3:0]        dir_req_type_r;
    logic [DATA_W-1:0] dir_req_data_r;
    logic [ADDR_W-1:0] dir_req_addr_r;
    logic              dir_requester_r;
    logic              busy_r;
    logic              ovf_err_r;
    logic              timeout_err_r;

    // FSM state, round-robin pointer, granted transaction and sticky error flags.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r         <= ST_IDLE;
            rr_r            <= 1'b0;
            tmo_r           <= '0;
            dir_req_en_r    <= 1'b0;
            dir_req_type_r  <= TYPE_NONE;
            dir_req_data_r  <= '0;
            dir_req_addr_r  <= '0;
            dir_requester_r <= 1'b0;
            busy_r          <= 1'b0;
            ovf_err_r       <= 1'b0;
            timeout_err_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            tmo_r         <= tmo_nxt_s;
            dir_req_en_r  <= (state_r == ST_ISSUE);
            busy_r        <= (state_nxt_s != ST_IDLE);
            ovf_err_r     <= ovf_err_r | ovf_s;
            timeout_err_r <= timeout_err_r | tmo_hit_s;
            if (grant_s) begin
                dir_req_type_r  <= win_entry_s[E_W-1 -: 4];
                dir_req_addr_r  <= win_entry_s[DATA_W +: ADDR_W];
                dir_req_data_r  <= win_entry_s[DATA_W-1:0];
                dir_requester_r <= winner_s;
                rr_r            <= ~winner_s;
            end
        end
    end

    assign cpu0_full_o     = full_s[0];
    assign cpu1_full_o     = full_s[1];
    assign dir_req_en_o    = dir_req_en_r;
    assign dir_req_type_o  = dir_req_type_r;
    assign dir_req_data_o  = dir_req_data_r;
    assign dir_req_addr_o  = dir_req_addr_r;
    assign dir_requester_o = dir_requester_r;
    assign busy_o          = busy_r;
    assign ovf_err_o       = ovf_err_r;
    assign timeout_err_o   = timeout_err_r;
endmodule

// File: tb/tb_dir_req_arbiter.sv
// Scoreboard bench for dir_req_arbiter: directed pushes queue expected grants,
// a monitor pops and compares on every directory request pulse.
module tb_dir_req_arbiter;
    localparam int AW = 32;
    localparam int DW = 128;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          c0_en = 1'b0, c1_en = 1'b0;
    logic [3:0]    c0_type = 4'h0, c1_type = 4'h0;
    logic [DW-1:0] c0_data = '0, c1_data = '0;
    logic [AW-1:0] c0_addr = '0, c1_addr = '0;
    logic          c0_full, c1_full;
    logic          dir_en;
    logic [3:0]    dir_type;
    logic [DW-1:0] dir_data;
    logic [AW-1:0] dir_addr;
    logic          dir_req;
    logic          dir_done = 1'b0;
    logic          busy, ovf_err, tmo_err;

    typedef struct packed {
        logic          req;
        logic [3:0]    typ;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   done_delay = -1;

    dir_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .TIMEOUT(8)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cpu0_req_en_i(c0_en), .cpu0_req_type_i(c0_type), .cpu0_req_data_i(c0_data),
        .cpu0_req_addr_i(c0_addr), .cpu0_full_o(c0_full),
        .cpu1_req_en_i(c1_en), .cpu1_req_type_i(c1_type), .cpu1_req_data_i(c1_data),
        .cpu1_req_addr_i(c1_addr), .cpu1_full_o(c1_full),
        .dir_req_en_o(dir_en), .dir_req_type_o(dir_type), .dir_req_data_o(dir_data),
        .dir_req_addr_o(dir_addr), .dir_requester_o(dir_req), .dir_done_i(dir_done),
        .busy_o(busy), .ovf_err_o(ovf_err), .timeout_err_o(tmo_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic req, input logic [3:0] typ, input logic [AW-1:0] addr);
        exp_t e;
        e.req  = req;
        e.typ  = typ;
        e.addr = addr;
        e.data = {4{addr}};
        return e;
    endfunction

    // Scoreboard monitor: every pulse must match the oldest expected grant.
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst && dir_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {127'h0, dir_en}, '0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_requester", {127'h0, dir_req}, {127'h0, e.req});
                    check("grant_type", {124'h0, dir_type}, {124'h0, e.typ});
                    check("grant_addr", {96'h0, dir_addr}, {96'h0, e.addr});
                    check("grant_data", dir_data, e.data);
                end
            end
        end
    end

    // Directory model: answers done a programmable number of cycles after each pulse.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (!sys_rst && dir_en === 1'b1 && done_delay >= 0) begin
                repeat (done_delay) @(posedge sys_clk);
                #1 dir_done = 1'b1;
                @(posedge sys_clk);
                #1 dir_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic do_reset();
        sys_rst = 1'b1;
        exp_q.delete();
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
    endtask

    task automatic drive(input logic e0, input logic [3:0] t0, input logic [AW-1:0] a0,
                         input logic e1, input logic [3:0] t1, input logic [AW-1:0] a1);
        c0_en = e0; c0_type = t0; c0_addr = a0; c0_data = {4{a0}};
        c1_en = e1; c1_type = t1; c1_addr = a1; c1_data = {4{a1}};
        @(posedge sys_clk);
        #1;
        c0_en = 1'b0;
        c1_en = 1'b0;
    endtask

    task automatic wait_pulse(input string nm);
        int n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (dir_en !== 1'b1 && n < 40);
        if (dir_en !== 1'b1) check(nm, {127'h0, dir_en}, {127'h0, 1'b1});
    endtask

    // Counts cycles after a pulse until busy falls.
    task automatic busy_len(output int n);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (busy === 1'b1 && n < 40);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while ((busy !== 1'b0 || exp_q.size() != 0) && n < 300);
        check(nm, {127'h0, busy}, '0);
    endtask

    initial begin
        int n;
        int pulses;
        logic [2:0] en_hist, busy_hist;

        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        check("rst_en", {127'h0, dir_en}, '0);
        check("rst_busy", {127'h0, busy}, '0);
        check("rst_full", {126'h0, c1_full, c0_full}, '0);
        check("rst_errs", {126'h0, tmo_err, ovf_err}, '0);
        check("rst_type", {124'h0, dir_type}, '0);
        check("rst_addr_req", {95'h0, dir_addr, dir_req}, '0);

        // Single CPU1 push: pulse two cycles after the push edge, busy until done.
        done_delay = 3;
        @(posedge sys_clk); #1;
        exp_q.push_back(mk(1'b1, 4'h2, 32'h40));
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h2, 32'h40);
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            en_hist[i]   = dir_en;
            busy_hist[i] = busy;
        end
        check("t1_latency", {125'h0, en_hist}, {125'h0, 3'b100});
        check("t1_busy_ramp", {125'h0, busy_hist}, {125'h0, 3'b110});
        busy_len(n);
        check("t1_busy_until_done", 128'(n), 128'd4);
        wait_idle("t1_drain");

        // Both CPUs push 3 entries together; grants alternate starting with CPU0.
        do_reset();
        done_delay = 1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(1'b0, 4'h1, 32'h1000 + 32'(i)));
            exp_q.push_back(mk(1'b1, 4'h3, 32'h2000 + 32'(i)));
        end
        for (int i = 0; i < 3; i++) drive(1'b1, 4'h1, 32'h1000 + 32'(i), 1'b1, 4'h3, 32'h2000 + 32'(i));
        wait_idle("rr_drain");

        // Overflow: arbiter stalled on CPU1, CPU0 pushes 5; 5th is dropped.
        do_reset();
        done_delay = -1;
        exp_q.push_back(mk(1'b1, 4'h5, 32'h77));
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h5, 32'h77);
        wait_pulse("ovf_first_pulse");
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, 4'h6, 32'h300 + 32'(i)));
        for (int i = 0; i < 3; i++) drive(1'b1, 4'h6, 32'h300 + 32'(i), 1'b0, 4'h0, 32'h0);
        check("ovf_not_full_at_3", {127'h0, c0_full}, '0);
        drive(1'b1, 4'h6, 32'h303, 1'b0, 4'h0, 32'h0);
        check("ovf_full_at_4", {127'h0, c0_full}, {127'h0, 1'b1});
        check("ovf_err_clear_before", {127'h0, ovf_err}, '0);
        drive(1'b1, 4'h6, 32'h555, 1'b0, 4'h0, 32'h0);
        check("ovf_err_set", {127'h0, ovf_err}, {127'h0, 1'b1});
        check("ovf_full_held", {127'h0, c0_full}, {127'h0, 1'b1});
        done_delay = 1;
        wait_idle("ovf_drain");
        check("ovf_err_sticky", {127'h0, ovf_err}, {127'h0, 1'b1});
        check("ovf_full_released", {127'h0, c0_full}, '0);
        check("ovf_stall_timed_out", {127'h0, tmo_err}, {127'h0, 1'b1});

        // Timeout: no done, forced release after 8 WAIT cycles, then next entry issues.
        do_reset();
        done_delay = -1;
        exp_q.push_back(mk(1'b1, 4'h7, 32'hA0));
        exp_q.push_back(mk(1'b0, 4'h8, 32'hB0));
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h7, 32'hA0);
        drive(1'b1, 4'h8, 32'hB0, 1'b1, 4'h9, 32'hC0);
        drive(1'b1, 4'hA, 32'hD0, 1'b0, 4'h0, 32'h0);
        wait_pulse("tmo_first_pulse");
        check("tmo_err_before", {127'h0, tmo_err}, '0);
        busy_len(n);
        check("tmo_wait_len", 128'(n), 128'd8);
        check("tmo_err_set", {127'h0, tmo_err}, {127'h0, 1'b1});
        wait_pulse("tmo_next_pulse");
        check("tmo_queue_consumed", 128'(exp_q.size()), '0);

        // Reset during WAIT with two entries still buffered.
        @(posedge sys_clk); #1;
        do_reset();
        @(negedge sys_clk);
        check("mid_rst_busy", {127'h0, busy}, '0);
        check("mid_rst_full", {126'h0, c1_full, c0_full}, '0);
        check("mid_rst_errs", {126'h0, tmo_err, ovf_err}, '0);
        check("mid_rst_outputs", {91'h0, dir_type, dir_addr, dir_req}, '0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (dir_en === 1'b1) pulses++;
        end
        check("mid_rst_no_pulses", 128'(pulses), '0);
        check("mid_rst_still_idle", {127'h0, busy}, '0);

        // Round-robin pointer was reset to CPU0 (last winner before reset was CPU0).
        done_delay = 1;
        exp_q.push_back(mk(1'b0, 4'hB, 32'hE0));
        exp_q.push_back(mk(1'b1, 4'hC, 32'hF0));
        @(posedge sys_clk); #1;
        drive(1'b1, 4'hB, 32'hE0, 1'b1, 4'hC, 32'hF0);
        wait_idle("rr_after_rst_drain");

        // Done arrives on the exact cycle the counter reaches TIMEOUT: no error.
        do_reset();
        done_delay = 7;
        exp_q.push_back(mk(1'b0, 4'hD, 32'h123));
        drive(1'b1, 4'hD, 32'h123, 1'b0, 4'h0, 32'h0);
        wait_pulse("tie_pulse");
        busy_len(n);
        check("tie_wait_len", 128'(n), 128'd8);
        check("tie_no_tmo_err", {127'h0, tmo_err}, '0);
        wait_idle("tie_drain");

        check("final_queue_empty", 128'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
